// File: rtl/fetch_unit_pkg.sv
// Shared fetch-sequencer types: FSM state encoding and counter width.
package fetch_def;
  typedef enum logic [1:0] {F_IDLE, F_RUN, F_HALTED} FetchState;
  localparam int CNT_W = 16;
endpackage

// File: rtl/fetch_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; parks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              q <= '0;
    else if (clr)              q <= '0;
    else if (inc && (q != '1)) q <= q + 1'b1;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns PC, run/halt FSM and retired-instruction count.
module fetch_unit
  import fetch_def::*;
#(
  parameter int A          = 16,
  parameter int OV         = 1000,
  parameter int RESET_ADDR = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stall,
  input  logic             ctrl_branch,
  input  logic             take_branch,
  input  logic [A-1:0]     inst_addr_in,
  input  logic             halt_req,
  output logic [A-1:0]     pc,
  output logic             pc_valid,
  output logic             halt,
  output logic             overflow,
  output logic [CNT_W-1:0] inst_count
);
  // Range checks done at 32 bits so OV may equal 2^A.
  localparam logic [31:0] OV_LIM = 32'(OV);

  FetchState      state, state_nxt;
  logic [A-1:0]   pc_nxt;
  logic           ovf_nxt, cnt_clr, cnt_inc;
  logic           tgt_ok, pc_last;

  assign tgt_ok  = 32'(inst_addr_in) < OV_LIM;
  assign pc_last = 32'(pc) == (OV_LIM - 32'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= F_IDLE;
      pc       <= A'(RESET_ADDR);
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      overflow <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ovf_nxt   = overflow;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    if (start) begin
      state_nxt = F_RUN;
      pc_nxt    = A'(RESET_ADDR);
      ovf_nxt   = 1'b0;
      cnt_clr   = 1'b1;
    end else if (state == F_RUN && !stall) begin
      // Every unstalled RUN cycle retires exactly one instruction, halting ones included.
      cnt_inc = 1'b1;
      if (halt_req) begin
        state_nxt = F_HALTED;
      end else if (ctrl_branch && take_branch) begin
        if (tgt_ok) pc_nxt = inst_addr_in;
        else begin
          state_nxt = F_HALTED;
          ovf_nxt   = 1'b1;
        end
      end else if (pc_last) begin
        state_nxt = F_HALTED;
        ovf_nxt   = 1'b1;
      end else begin
        pc_nxt = pc + 1'b1;
      end
    end
  end

  assign pc_valid = (state == F_RUN);
  assign halt     = (state == F_HALTED);

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .q       (inst_count)
  );
endmodule
